// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
//
// Arbiter and sequencer for the single-port 128x8 data RAM. Two requesters
// share the RAM: the CPU core (port 0, priority) and a DMA/debug loader
// (port 1). Each cycle at most one single-beat read or write is granted and
// driven onto the RAM. Read data is routed back to the port that issued the
// read one cycle later.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   defined   : a starve counter forces a DMA grant after STARVE_MAX
//               consecutive denied DMA cycles.
//   undefined : strict CPU priority; DMA may wait indefinitely.
//
// Parameters
//   ADDR_W     RAM address width (7 -> 128 entries)
//   DATA_W     RAM data width
//   STARVE_MAX denied DMA cycles before a forced DMA grant (1..15)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU access request (held until cpu_gnt)
//   dma_req/we/addr/wdata    DMA access request (held until dma_gnt)
//   cpu_gnt, dma_gnt         combinational: access accepted at this edge
//   cpu_rvalid, dma_rvalid   registered: read data valid this cycle
//   cpu_rdata, dma_rdata     ram_q while own rvalid is high, else 0
//   ram_addr, ram_data       address / write data to the RAM
//   ram_en                   RAM write enable
//   ram_q                    RAM read data, valid the cycle after ram_addr
//   owner                    registered last grant: 00 none, 01 CPU, 10 DMA
// -----------------------------------------------------------------------------
module data_ram_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_q,

  output logic [1:0]        owner
);

  // The state encoding is the owner code seen on the port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_DMA  = 2'b10
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic   cpu_gnt_s;
  logic   dma_gnt_s;
  logic   force_dma_s;

  // One pending-read flag per port: set by a granted read, consumed the
  // following cycle when ram_q carries that read's data.
  logic   rd_pend_cpu_r;
  logic   rd_pend_dma_r;

  // Elaboration-time guard on the starve limit (counter is 4 bits wide).
  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("data_ram_arbiter: STARVE_MAX must be in 1..15");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int               CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_r;

  // Starve counter: counts consecutive cycles in which DMA asks but is not
  // served. It restarts whenever DMA is served or stops asking, so only an
  // unbroken run of denials can reach the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!dma_req || dma_gnt_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (starve_cnt_r != STARVE_LIM) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // The counter is registered, so force_dma never loops back through the
  // grant decode within one cycle.
  assign force_dma_s = (starve_cnt_r == STARVE_LIM);
`else
  assign force_dma_s = 1'b0;
`endif

  // Arbitration: next state is the port granted this cycle. Nothing is
  // granted while reset is asserted, which also suppresses any write.
  always_comb begin
    state_next_s = ST_IDLE;
    if (rst) begin
      state_next_s = ST_IDLE;
    end else if (cpu_req && dma_req) begin
      if (force_dma_s) begin
        state_next_s = ST_DMA;
      end else begin
        state_next_s = ST_CPU;
      end
    end else if (cpu_req) begin
      state_next_s = ST_CPU;
    end else if (dma_req) begin
      state_next_s = ST_DMA;
    end else begin
      state_next_s = ST_IDLE;
    end
  end

  // Grant and RAM drive decode from the chosen owner. With no grant the RAM
  // bus is parked at zero and the write enable is low.
  always_comb begin
    cpu_gnt_s = 1'b0;
    dma_gnt_s = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_data  = {DATA_W{1'b0}};
    ram_en    = 1'b0;
    case (state_next_s)
      ST_CPU: begin
        cpu_gnt_s = 1'b1;
        ram_addr  = cpu_addr;
        ram_data  = cpu_wdata;
        ram_en    = cpu_we;
      end
      ST_DMA: begin
        dma_gnt_s = 1'b1;
        ram_addr  = dma_addr;
        ram_data  = dma_wdata;
        ram_en    = dma_we;
      end
      default: begin
        cpu_gnt_s = 1'b0;
        dma_gnt_s = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_data  = {DATA_W{1'b0}};
        ram_en    = 1'b0;
      end
    endcase
  end

  // Owner state register and read-return pipeline. Reset drops any pending
  // read so no stale rvalid appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      rd_pend_cpu_r <= 1'b0;
      rd_pend_dma_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      rd_pend_cpu_r <= cpu_gnt_s && !cpu_we;
      rd_pend_dma_r <= dma_gnt_s && !dma_we;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign dma_gnt    = dma_gnt_s;
  assign owner      = state_r;
  assign cpu_rvalid = rd_pend_cpu_r;
  assign dma_rvalid = rd_pend_dma_r;

  // ram_q is shared; each port sees it only in its own return cycle.
  assign cpu_rdata  = rd_pend_cpu_r ? ram_q : {DATA_W{1'b0}};
  assign dma_rdata  = rd_pend_dma_r ? ram_q : {DATA_W{1'b0}};

endmodule

// File: tb/tb_data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_ram_arbiter
//
// Self-checking bench for data_ram_arbiter. A small behavioural RAM model
// sits on the RAM side. A cycle-by-cycle vector table covers reset, CPU
// write/read-back, contention, DMA write/read and alternating reads; short
// hand-written sequences cover starvation and reset in mid-operation.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_data_ram_arbiter;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_en;
  logic [DATA_W-1:0] ram_q = 8'h00;
  logic [1:0]        owner;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [0:127];

  always #5 clk = ~clk;

  // Single-port synchronous RAM: write on ram_en, registered read.
  always @(posedge clk) begin
    if (ram_en) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  data_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en(ram_en), .ram_q(ram_q),
    .owner(owner)
  );

  typedef struct {
    logic       rst;
    logic       creq, cwe;
    logic [6:0] caddr;
    logic [7:0] cwd;
    logic       dreq, dwe;
    logic [6:0] daddr;
    logic [7:0] dwd;
    logic       e_cg, e_dg, e_en;
    logic [6:0] e_addr;
    logic [7:0] e_data;
    logic [1:0] e_own;
    logic       e_cv;
    logic [7:0] e_cd;
    logic       e_dv;
    logic [7:0] e_dd;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic r, input logic cr, input logic cw, input logic [6:0] ca, input logic [7:0] cd,
    input logic dr, input logic dw, input logic [6:0] da, input logic [7:0] dd,
    input logic ecg, input logic edg, input logic een, input logic [6:0] ea, input logic [7:0] ed,
    input logic [1:0] eo, input logic ecv, input logic [7:0] ecd, input logic edv, input logic [7:0] edd);
    vec_t v;
    v.rst = r; v.creq = cr; v.cwe = cw; v.caddr = ca; v.cwd = cd;
    v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwd = dd;
    v.e_cg = ecg; v.e_dg = edg; v.e_en = een; v.e_addr = ea; v.e_data = ed;
    v.e_own = eo; v.e_cv = ecv; v.e_cd = ecd; v.e_dv = edv; v.e_dd = edd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r,
                        input logic cr, input logic cw, input logic [6:0] ca, input logic [7:0] cd,
                        input logic dr, input logic dw, input logic [6:0] da, input logic [7:0] dd);
    rst = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  // Advance to the next cycle, apply inputs, and stop at mid-cycle to sample.
  task automatic cyc(input logic r,
                     input logic cr, input logic cw, input logic [6:0] ca, input logic [7:0] cd,
                     input logic dr, input logic dw, input logic [6:0] da, input logic [7:0] dd);
    @(posedge clk);
    #1;
    set_in(r, cr, cw, ca, cd, dr, dw, da, dd);
    @(negedge clk);
  endtask

  initial begin
    //        rst  cpu: req we addr  wdata  dma: req we addr  wdata   exp: cg dg en addr  data  own cv cdata dv ddata
    tbl[0]  = mk(1, 1,0,7'h00,8'h00, 1,0,7'h01,8'h00, 0,0,0,7'h00,8'h00, 2'b00, 0,8'h00, 0,8'h00);
    tbl[1]  = mk(0, 1,1,7'h10,8'h5A, 0,0,7'h00,8'h00, 1,0,1,7'h10,8'h5A, 2'b00, 0,8'h00, 0,8'h00);
    tbl[2]  = mk(0, 1,0,7'h10,8'h00, 0,0,7'h00,8'h00, 1,0,0,7'h10,8'h00, 2'b01, 0,8'h00, 0,8'h00);
    tbl[3]  = mk(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 2'b01, 1,8'h5A, 0,8'h00);
    tbl[4]  = mk(0, 1,0,7'h20,8'h00, 1,1,7'h20,8'h33, 1,0,0,7'h20,8'h00, 2'b00, 0,8'h00, 0,8'h00);
    tbl[5]  = mk(0, 0,0,7'h00,8'h00, 1,1,7'h20,8'h33, 0,1,1,7'h20,8'h33, 2'b01, 1,8'hC3, 0,8'h00);
    tbl[6]  = mk(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 2'b10, 0,8'h00, 0,8'h00);
    tbl[7]  = mk(0, 1,0,7'h20,8'h00, 0,0,7'h00,8'h00, 1,0,0,7'h20,8'h00, 2'b00, 0,8'h00, 0,8'h00);
    tbl[8]  = mk(0, 0,0,7'h00,8'h00, 1,0,7'h20,8'h00, 0,1,0,7'h20,8'h00, 2'b01, 1,8'h33, 0,8'h00);
    tbl[9]  = mk(0, 1,0,7'h04,8'h00, 1,0,7'h03,8'h00, 1,0,0,7'h04,8'h00, 2'b10, 0,8'h00, 1,8'h33);
    tbl[10] = mk(0, 0,0,7'h00,8'h00, 1,0,7'h03,8'h00, 0,1,0,7'h03,8'h00, 2'b01, 1,8'h84, 0,8'h00);
    tbl[11] = mk(0, 1,0,7'h00,8'h00, 0,0,7'h00,8'h00, 1,0,0,7'h00,8'h00, 2'b10, 0,8'h00, 1,8'h83);
    tbl[12] = mk(0, 0,0,7'h00,8'h00, 1,0,7'h01,8'h00, 0,1,0,7'h01,8'h00, 2'b01, 1,8'h80, 0,8'h00);
    tbl[13] = mk(0, 1,0,7'h02,8'h00, 0,0,7'h00,8'h00, 1,0,0,7'h02,8'h00, 2'b10, 0,8'h00, 1,8'h81);
    tbl[14] = mk(0, 0,0,7'h00,8'h00, 1,0,7'h03,8'h00, 0,1,0,7'h03,8'h00, 2'b01, 1,8'h82, 0,8'h00);
    tbl[15] = mk(0, 1,0,7'h04,8'h00, 0,0,7'h00,8'h00, 1,0,0,7'h04,8'h00, 2'b10, 0,8'h00, 1,8'h83);
    tbl[16] = mk(0, 0,0,7'h00,8'h00, 1,0,7'h05,8'h00, 0,1,0,7'h05,8'h00, 2'b01, 1,8'h84, 0,8'h00);
    tbl[17] = mk(0, 1,0,7'h06,8'h00, 0,0,7'h00,8'h00, 1,0,0,7'h06,8'h00, 2'b10, 0,8'h00, 1,8'h85);
    tbl[18] = mk(0, 0,0,7'h00,8'h00, 1,0,7'h07,8'h00, 0,1,0,7'h07,8'h00, 2'b01, 1,8'h86, 0,8'h00);
    tbl[19] = mk(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 2'b10, 0,8'h00, 1,8'h87);
    tbl[20] = mk(0, 0,0,7'h00,8'h00, 0,0,7'h00,8'h00, 0,0,0,7'h00,8'h00, 2'b00, 0,8'h00, 0,8'h00);

    // RAM contents: zero, 0x80..0x87 at 0x00..0x07, 0xC3 at 0x20.
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = 8'h80 + 8'(i);
    mem[7'h20] = 8'hC3;

    // First reset cycle, both ports requesting.
    set_in(1'b1, 1'b1, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 7'h01, 8'h00);
    @(negedge clk);
    chk("rst0_cpu_gnt", 8'(cpu_gnt), 8'h00);
    chk("rst0_dma_gnt", 8'(dma_gnt), 8'h00);
    chk("rst0_ram_en",  8'(ram_en),  8'h00);

    for (int v = 0; v < NV; v++) begin
      cyc(tbl[v].rst, tbl[v].creq, tbl[v].cwe, tbl[v].caddr, tbl[v].cwd,
          tbl[v].dreq, tbl[v].dwe, tbl[v].daddr, tbl[v].dwd);
      chk($sformatf("v%0d_cpu_gnt", v),    8'(cpu_gnt),    8'(tbl[v].e_cg));
      chk($sformatf("v%0d_dma_gnt", v),    8'(dma_gnt),    8'(tbl[v].e_dg));
      chk($sformatf("v%0d_ram_en", v),     8'(ram_en),     8'(tbl[v].e_en));
      chk($sformatf("v%0d_ram_addr", v),   8'(ram_addr),   8'(tbl[v].e_addr));
      chk($sformatf("v%0d_ram_data", v),   ram_data,       tbl[v].e_data);
      chk($sformatf("v%0d_owner", v),      8'(owner),      8'(tbl[v].e_own));
      chk($sformatf("v%0d_cpu_rvalid", v), 8'(cpu_rvalid), 8'(tbl[v].e_cv));
      chk($sformatf("v%0d_cpu_rdata", v),  cpu_rdata,      tbl[v].e_cd);
      chk($sformatf("v%0d_dma_rvalid", v), 8'(dma_rvalid), 8'(tbl[v].e_dv));
      chk($sformatf("v%0d_dma_rdata", v),  dma_rdata,      tbl[v].e_dd);
    end

    // Starvation: both ports request continuously. With the guard, DMA wins
    // every (STARVE_MAX+1)th cycle; without it, never.
    for (int i = 0; i < 15; i++) begin
      logic exp_dg;
      exp_dg = GUARD && ((i % (STARVE_MAX + 1)) == STARVE_MAX);
      cyc(1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 7'h01, 8'h00);
      chk($sformatf("starve%0d_dma_gnt", i), 8'(dma_gnt), 8'(exp_dg));
      chk($sformatf("starve%0d_cpu_gnt", i), 8'(cpu_gnt), 8'(!exp_dg));
    end

    // Reset right after a DMA read; a CPU write during reset must not land.
    cyc(1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 7'h05, 8'h00);
    chk("rr_dma_gnt", 8'(dma_gnt), 8'h01);
    cyc(1'b1, 1'b1, 1'b1, 7'h06, 8'hEE, 1'b1, 1'b0, 7'h05, 8'h00);
    chk("rr_rst_cpu_gnt", 8'(cpu_gnt), 8'h00);
    chk("rr_rst_dma_gnt", 8'(dma_gnt), 8'h00);
    chk("rr_rst_ram_en",  8'(ram_en),  8'h00);
    cyc(1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00);
    chk("rr_dma_rvalid", 8'(dma_rvalid), 8'h00);
    chk("rr_dma_rdata",  dma_rdata,      8'h00);
    chk("rr_owner",      8'(owner),      8'h00);
    cyc(1'b0, 1'b1, 1'b0, 7'h06, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00);
    chk("rr_rd_cpu_gnt", 8'(cpu_gnt), 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00);
    chk("rr_cpu_rvalid", 8'(cpu_rvalid), 8'h01);
    chk("rr_cpu_rdata",  cpu_rdata,      8'h86);

    // Reset clears a partly built-up starve count: after 3 denials and a
    // reset cycle, DMA again needs a full STARVE_MAX denials.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 7'h01, 8'h00);
      chk($sformatf("sc_pre%0d_cpu_gnt", i), 8'(cpu_gnt), 8'h01);
    end
    cyc(1'b1, 1'b1, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 7'h01, 8'h00);
    chk("sc_rst_dma_gnt", 8'(dma_gnt), 8'h00);
    for (int i = 0; i < 5; i++) begin
      logic exp_dg;
      exp_dg = GUARD && (i == STARVE_MAX);
      cyc(1'b0, 1'b1, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 7'h01, 8'h00);
      chk($sformatf("sc_post%0d_dma_gnt", i), 8'(dma_gnt), 8'(exp_dg));
    end

    cyc(1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
